// File: rtl/exe_stage.sv
// Execute stage: builds Val2 from the shifter operand, runs the ALU, computes the
// branch target, owns the NZCV register and drives the EX/MEM pipeline register.
module exe_stage #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic         wb_en,
  input  logic         mem_r_en,
  input  logic         mem_w_en,
  input  logic         s,
  input  logic         b,
  input  logic         imm,
  input  logic [3:0]   exe_cmd,
  input  logic [3:0]   dest,
  input  logic [3:0]   status_in,
  input  logic [n-1:0] val_rn,
  input  logic [n-1:0] val_rm,
  input  logic [n-1:0] pc,
  input  logic [23:0]  imm_24,
  input  logic [11:0]  shift_operand,
  output logic [3:0]   status,
  output logic         branch_taken,
  output logic [n-1:0] branch_addr,
  output logic         wb_en_o,
  output logic         mem_r_en_o,
  output logic         mem_w_en_o,
  output logic [n-1:0] alu_res_o,
  output logic [n-1:0] st_val_o,
  output logic [3:0]   dest_o
);

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } alu_cmd_e;

  // ---------------------------------------------------------------- Val2
  logic [n-1:0]   val2;
  logic [n-1:0]   imm_rot;
  logic [n-1:0]   rm_shift;
  logic [2*n-1:0] imm_dbl;
  logic [2*n-1:0] rm_dbl;
  logic [4:0]     rot_amt;
  logic [4:0]     sh_amt;

  // A right shift of the value concatenated with itself yields the rotation
  // in the low half.
  always_comb begin
    rot_amt = {shift_operand[11:8], 1'b0};
    sh_amt  = shift_operand[11:7];
    imm_dbl = {2{{(n-8){1'b0}}, shift_operand[7:0]}} >> rot_amt;
    imm_rot = imm_dbl[n-1:0];
    rm_dbl  = {val_rm, val_rm} >> sh_amt;

    case (shift_operand[6:5])
      2'b00:   rm_shift = val_rm << sh_amt;
      2'b01:   rm_shift = val_rm >> sh_amt;
      2'b10:   rm_shift = $signed(val_rm) >>> sh_amt;
      default: rm_shift = rm_dbl[n-1:0];
    endcase

    if (mem_r_en || mem_w_en) begin
      val2 = {{(n-12){1'b0}}, shift_operand};
    end else if (imm) begin
      val2 = imm_rot;
    end else begin
      val2 = rm_shift;
    end
  end

  // ---------------------------------------------------------------- ALU
  logic [n:0]   sum;
  logic [n-1:0] alu_res;
  logic         is_add;
  logic         is_sub;
  logic         c_flag;
  logic         v_flag;
  logic [3:0]   nzcv;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    sum     = '0;
    alu_res = '0;
    is_add  = 1'b0;
    is_sub  = 1'b0;
    // Logic, move and unknown commands carry C and V through from the snapshot.
    c_flag  = status_in[1];
    v_flag  = status_in[0];

    case (exe_cmd)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_ADD: begin
        is_add = 1'b1;
        sum    = {1'b0, val_rn} + {1'b0, val2};
      end
      CMD_ADC: begin
        is_add = 1'b1;
        sum    = {1'b0, val_rn} + {1'b0, val2} + {{n{1'b0}}, status_in[1]};
      end
      // Subtraction as Rn + ~Val2 + 1 makes the carry-out equal NOT borrow.
      CMD_SUB: begin
        is_sub = 1'b1;
        sum    = {1'b0, val_rn} + {1'b0, ~val2} + {{n{1'b0}}, 1'b1};
      end
      CMD_SBC: begin
        is_sub = 1'b1;
        sum    = {1'b0, val_rn} + {1'b0, ~val2} + {{n{1'b0}}, status_in[1]};
      end
      CMD_AND: alu_res = val_rn & val2;
      CMD_ORR: alu_res = val_rn | val2;
      CMD_EOR: alu_res = val_rn ^ val2;
      default: alu_res = '0;
    endcase

    if (is_add || is_sub) begin
      alu_res = sum[n-1:0];
      c_flag  = sum[n];
    end
    if (is_add) begin
      v_flag = (val_rn[n-1] == val2[n-1]) && (alu_res[n-1] != val_rn[n-1]);
    end else if (is_sub) begin
      v_flag = (val_rn[n-1] != val2[n-1]) && (alu_res[n-1] != val_rn[n-1]);
    end

    nzcv = {alu_res[n-1], (alu_res == '0), c_flag, v_flag};
  end

  // ---------------------------------------------------------------- branch
  assign branch_taken = b;
  assign branch_addr  = pc + {{(n-26){imm_24[23]}}, imm_24, 2'b00};

  // ---------------------------------------------------------------- EX/MEM and status
  logic         wb_en_d,    wb_en_q;
  logic         mem_r_en_d, mem_r_en_q;
  logic         mem_w_en_d, mem_w_en_q;
  logic [n-1:0] alu_res_d,  alu_res_q;
  logic [n-1:0] st_val_d,   st_val_q;
  logic [3:0]   dest_d,     dest_q;
  logic [3:0]   status_d,   status_q;

  always_comb begin
    wb_en_d    = wb_en_q;
    mem_r_en_d = mem_r_en_q;
    mem_w_en_d = mem_w_en_q;
    alu_res_d  = alu_res_q;
    st_val_d   = st_val_q;
    dest_d     = dest_q;
    status_d   = status_q;
    if (!freeze) begin
      wb_en_d    = wb_en;
      mem_r_en_d = mem_r_en;
      mem_w_en_d = mem_w_en;
      alu_res_d  = alu_res;
      st_val_d   = val_rm;
      dest_d     = dest;
      if (s) begin
        status_d = nzcv;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // its _d value from before the edge; the combinational blocks above use
  // blocking assignments because they describe ordered evaluation, not state.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and checked before the hold path, so a reset
    // edge clears the stage even while freeze is asserted.
    if (rst) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      alu_res_q  <= '0;
      st_val_q   <= '0;
      dest_q     <= '0;
      status_q   <= '0;
    end else begin
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      mem_w_en_q <= mem_w_en_d;
      alu_res_q  <= alu_res_d;
      st_val_q   <= st_val_d;
      dest_q     <= dest_d;
      status_q   <= status_d;
    end
  end

  assign wb_en_o    = wb_en_q;
  assign mem_r_en_o = mem_r_en_q;
  assign mem_w_en_o = mem_w_en_q;
  assign alu_res_o  = alu_res_q;
  assign st_val_o   = st_val_q;
  assign dest_o     = dest_q;
  assign status     = status_q;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases plus randomized traffic,
// compared against an arithmetic reference model of the execute stage.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst, freeze, wb_en, mem_r_en, mem_w_en, s, b, imm;
  logic [3:0]  exe_cmd, dest, status_in;
  logic [31:0] val_rn, val_rm, pc;
  logic [23:0] imm_24;
  logic [11:0] shift_operand;
  logic [3:0]  status;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        wb_en_o, mem_r_en_o, mem_w_en_o;
  logic [31:0] alu_res_o, st_val_o;
  logic [3:0]  dest_o;

  int checks = 0;
  int errors = 0;

  // Reference model of the registered state
  logic        m_wb, m_mr, m_mw;
  logic [31:0] m_res, m_st;
  logic [3:0]  m_dest, m_status;

  always #5 clk = ~clk;

  exe_stage #(.n(32)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .wb_en(wb_en), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .s(s), .b(b), .imm(imm), .exe_cmd(exe_cmd), .dest(dest),
    .status_in(status_in), .val_rn(val_rn), .val_rm(val_rm), .pc(pc),
    .imm_24(imm_24), .shift_operand(shift_operand), .status(status),
    .branch_taken(branch_taken), .branch_addr(branch_addr), .wb_en_o(wb_en_o),
    .mem_r_en_o(mem_r_en_o), .mem_w_en_o(mem_w_en_o), .alu_res_o(alu_res_o),
    .st_val_o(st_val_o), .dest_o(dest_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_ror(input logic [31:0] x, input int r);
    logic [31:0] y;
    y = x;
    for (int i = 0; i < r; i++) y = {y[0], y[31:1]};
    return y;
  endfunction

  function automatic logic [31:0] m_val2(input logic memop, input logic im,
                                         input logic [11:0] so, input logic [31:0] rm);
    int          amt;
    longint      t;
    logic [31:0] r;
    if (memop) return {20'd0, so};
    if (im) return m_ror({24'd0, so[7:0]}, 2 * int'(so[11:8]));
    amt = int'(so[11:7]);
    case (so[6:5])
      2'b00:   r = rm << amt;
      2'b01:   r = rm >> amt;
      2'b10: begin
        t = longint'($signed(rm)) >>> amt;
        r = t[31:0];
      end
      default: r = m_ror(rm, amt);
    endcase
    return r;
  endfunction

  // Returns {result, N, Z, C, V}; V is true when the exact signed result does
  // not fit in 32 bits, C compares unsigned magnitudes.
  function automatic logic [35:0] m_alu(input logic [3:0] cmd, input logic [31:0] rn,
                                        input logic [31:0] v2, input logic [3:0] st);
    logic [31:0] res;
    logic        c, v, cin;
    longint      u, sres, srn, sv2, bw;
    cin = st[1];
    c   = st[1];
    v   = st[0];
    res = 32'd0;
    srn = longint'($signed(rn));
    sv2 = longint'($signed(v2));
    bw  = cin ? 64'sd0 : 64'sd1;
    case (cmd)
      4'd1: res = v2;
      4'd9: res = ~v2;
      4'd2, 4'd3: begin
        u    = longint'(rn) + longint'(v2) + ((cmd == 4'd3) ? longint'(cin) : 64'sd0);
        sres = srn + sv2 + ((cmd == 4'd3) ? longint'(cin) : 64'sd0);
        res  = u[31:0];
        c    = u[32];
        v    = (sres != longint'($signed(res)));
      end
      4'd4, 4'd5: begin
        u    = (cmd == 4'd5) ? bw : 64'sd0;
        sres = srn - sv2 - u;
        res  = rn - v2 - u[31:0];
        c    = longint'(rn) >= longint'(v2) + u;
        v    = (sres != longint'($signed(res)));
      end
      4'd6: res = rn & v2;
      4'd7: res = rn | v2;
      4'd8: res = rn ^ v2;
      default: res = 32'd0;
    endcase
    return {res, res[31], res == 32'd0, c, v};
  endfunction

  function automatic logic [31:0] m_branch(input logic [31:0] p, input logic [23:0] off);
    longint sum;
    sum = longint'(p) + 4 * longint'($signed(off));
    return sum[31:0];
  endfunction

  // Called 1 ns after a rising edge with inputs already applied.
  task automatic step();
    logic [31:0] v2;
    logic [35:0] a;
    #1;
    check("branch_taken", {31'd0, branch_taken}, {31'd0, b});
    check("branch_addr", branch_addr, m_branch(pc, imm_24));
    v2 = m_val2(mem_r_en | mem_w_en, imm, shift_operand, val_rm);
    a  = m_alu(exe_cmd, val_rn, v2, status_in);
    if (rst) begin
      {m_wb, m_mr, m_mw} = 3'b000;
      m_res = 0; m_st = 0; m_dest = 0; m_status = 0;
    end else if (!freeze) begin
      m_wb = wb_en; m_mr = mem_r_en; m_mw = mem_w_en;
      m_res = a[35:4]; m_st = val_rm; m_dest = dest;
      if (s) m_status = a[3:0];
    end
    @(posedge clk);
    #1;
    check("wb_en_o", {31'd0, wb_en_o}, {31'd0, m_wb});
    check("mem_r_en_o", {31'd0, mem_r_en_o}, {31'd0, m_mr});
    check("mem_w_en_o", {31'd0, mem_w_en_o}, {31'd0, m_mw});
    check("alu_res_o", alu_res_o, m_res);
    check("st_val_o", st_val_o, m_st);
    check("dest_o", {28'd0, dest_o}, {28'd0, m_dest});
    check("status", {28'd0, status}, {28'd0, m_status});
  endtask

  task automatic idle();
    rst = 0; freeze = 0; wb_en = 0; mem_r_en = 0; mem_w_en = 0; s = 0; b = 0; imm = 0;
    exe_cmd = 0; dest = 0; status_in = 0; val_rn = 0; val_rm = 0; pc = 0;
    imm_24 = 0; shift_operand = 0;
  endtask

  task automatic rand_inputs();
    int sel;
    wb_en = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
    b = 1'($urandom_range(0, 1)); imm = 1'($urandom_range(0, 1));
    mem_r_en = 0; mem_w_en = 0;
    exe_cmd = 4'($urandom_range(0, 15));
    sel = int'($urandom_range(0, 5));
    if (sel == 0) begin mem_r_en = 1; exe_cmd = 4'd2; end
    if (sel == 1) begin mem_w_en = 1; exe_cmd = 4'd2; end
    dest = 4'($urandom); status_in = 4'($urandom);
    val_rn = $urandom; val_rm = $urandom; pc = $urandom;
    case ($urandom_range(0, 4))
      0: val_rn = 32'h7FFF_FFFF;
      1: val_rn = 32'h8000_0000;
      2: val_rn = 32'hFFFF_FFFF;
      default: ;
    endcase
    imm_24 = 24'($urandom); shift_operand = 12'($urandom);
    if ($urandom_range(0, 9) == 0) begin
      wb_en = 0; mem_r_en = 0; mem_w_en = 0; s = 0; b = 0;
    end
  endtask

  logic [31:0] snap_res;
  logic [3:0]  snap_status;

  initial begin
    idle();
    rst = 1;
    val_rn = 32'h1234; exe_cmd = 4'd2; wb_en = 1; s = 1;
    step();
    step();
    check("rst_res", alu_res_o, 32'd0);
    check("rst_status", {28'd0, status}, 32'd0);

    // ADD 5 + 3
    idle(); exe_cmd = 4'd2; val_rn = 5; imm = 1; shift_operand = 12'h003; s = 1;
    wb_en = 1; dest = 4;
    step();
    check("add_res", alu_res_o, 32'd8);
    check("add_wb", {31'd0, wb_en_o}, 32'd1);
    check("add_dest", {28'd0, dest_o}, 32'd4);
    check("add_status", {28'd0, status}, 32'h0);

    // SUB 3 - 5, then ADD overflow
    idle(); exe_cmd = 4'd4; val_rn = 3; imm = 1; shift_operand = 12'h005; s = 1;
    step();
    check("sub_res", alu_res_o, 32'hFFFF_FFFE);
    check("sub_status", {28'd0, status}, 32'h8);
    idle(); exe_cmd = 4'd2; val_rn = 32'h7FFF_FFFF; imm = 1; shift_operand = 12'h001; s = 1;
    step();
    check("ovf_res", alu_res_o, 32'h8000_0000);
    check("ovf_status", {28'd0, status}, 32'h9);

    // Val2 modes
    idle(); exe_cmd = 4'd1; imm = 1; shift_operand = 12'h2FF;
    step();
    check("rot_imm", alu_res_o, 32'hF000_000F);
    idle(); exe_cmd = 4'd1; val_rm = 32'h8000_0000; shift_operand = {5'd4, 2'b10, 5'd0};
    step();
    check("asr", alu_res_o, 32'hF800_0000);
    idle(); exe_cmd = 4'd2; mem_w_en = 1; shift_operand = 12'hFFF; val_rn = 32'h100;
    val_rm = 32'hCAFE_BABE; imm = 1;
    step();
    check("st_addr", alu_res_o, 32'h0000_10FF);
    check("st_val", st_val_o, 32'hCAFE_BABE);
    check("st_status_kept", {28'd0, status}, 32'h9);

    // Backward branch
    idle(); b = 1; pc = 32'h100; imm_24 = 24'hFFFFFE;
    #1;
    check("br_taken", {31'd0, branch_taken}, 32'd1);
    check("br_addr", branch_addr, 32'h0000_00F8);
    #1;
    step();

    // Freeze for three cycles with s=1 and changing inputs
    snap_res = alu_res_o; snap_status = status;
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); freeze = 1; s = 1; rst = 0;
      step();
      check("frz_res", alu_res_o, snap_res);
      check("frz_status", {28'd0, status}, {28'd0, snap_status});
    end
    idle(); exe_cmd = 4'd7; val_rn = 32'hF0; imm = 1; shift_operand = 12'h00F; wb_en = 1; dest = 9;
    step();
    check("unfrz_res", alu_res_o, 32'h0000_00FF);

    // Reset mid-stream while frozen, held for two edges
    rand_inputs(); rst = 1; freeze = 1; s = 1; wb_en = 1; val_rn = 32'h55;
    step();
    check("midrst_res", alu_res_o, 32'd0);
    check("midrst_wb", {31'd0, wb_en_o}, 32'd0);
    check("midrst_status", {28'd0, status}, 32'd0);
    step();
    check("midrst2_status", {28'd0, status}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      freeze = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage: sits downstream of the ID/EX pipeline register and consumes its outputs (control bits, exe_cmd, val_rn, val_rm, pc, imm_24, shift_operand, dest, status).
- Generates Val2, runs the ALU and computes the branch target.
- Owns the architectural NZCV status register.
- Drives the EX/MEM register contents, so it is the reading end of the ID/EX interface and the writing end of EX/MEM.

Parameters:
- n, 32, datapath width; the ALU, Val2 and branch logic are defined for n=32 only.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- freeze  in  1  memory-stage stall; holds EX/MEM outputs and the status register
- wb_en, mem_r_en, mem_w_en, s, b, imm  in  1 each  control bits from ID/EX
- exe_cmd  in  4  ALU command
- dest  in  4  destination register index
- status_in  in  4  NZCV snapshot carried with the instruction, used as carry-in
- val_rn, val_rm, pc  in  n  operands and PC+4 of the instruction
- imm_24  in  24  branch offset
- shift_operand  in  12  ARM shifter operand field
- status  out  4  architectural NZCV register {N,Z,C,V}, feeds ID stage
- branch_taken  out  1  combinational, equals b
- branch_addr  out  n  combinational, pc + (sign-extended imm_24 << 2)
- wb_en_o, mem_r_en_o, mem_w_en_o  out  1 each  registered control bits
- alu_res_o  out  n  registered ALU result or memory address
- st_val_o  out  n  registered val_rm, used as store data
- dest_o  out  4  registered destination

Behaviour:
- Reset: on a rising clk edge with rst=1, all registered outputs go to 0 and status goes to 4'b0000. rst has priority over freeze.
- Val2 select:
  - mem_r_en|mem_w_en: zero-extended shift_operand[11:0].
  - Otherwise, imm=1: shift_operand[7:0] zero-extended, rotated right by 2*shift_operand[11:8].
  - Otherwise, imm=0: val_rm shifted by shift_operand[11:7]. Type from shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. Shift amount 0 means no shift.
- ALU, cin = status_in[1]:
  - 0001 MOV = Val2
  - 1001 MVN = ~Val2
  - 0010 ADD = Rn+Val2
  - 0011 ADC = Rn+Val2+cin
  - 0100 SUB = Rn-Val2
  - 0101 SBC = Rn-Val2-!cin
  - 0110 AND
  - 0111 ORR
  - 1000 EOR
  - Any other code: result 0, flags N/Z only.
  - Loads and stores arrive with exe_cmd=0010, so the address is Rn+Val2.
- Flags:
  - N = res[31].
  - Z = (res==0).
  - C for add types = carry-out of bit 31. C for sub types = NOT borrow (ARM convention). C for logic/move = unchanged.
  - V for add = operands same sign and result sign differs. V for sub = operand signs differ and result sign differs from Rn. V for logic = unchanged.
- Status register:
  - On clk edge with rst=0, freeze=0 and s=1, status <= computed NZCV; otherwise it holds.
  - Updated in the same edge that writes EX/MEM, so the instruction after next in ID sees the new flags.
- EX/MEM outputs:
  - freeze=0: capture {wb_en, mem_r_en, mem_w_en, alu_res, val_rm, dest} each cycle. Latency is 1 cycle from valid ID/EX outputs.
  - freeze=1: hold every registered output and status unchanged, regardless of inputs.
- Bubbles: a flushed ID/EX entry arrives with all controls 0. It must produce wb_en_o=mem_r_en_o=mem_w_en_o=0 and must not change status, because s=0.
- branch_taken/branch_addr:
  - Purely combinational from current inputs and unaffected by freeze.
  - The offset is signed: imm_24[23] replicated into bits 31:26.
  - The addition wraps modulo 2^32.
- Simultaneous events: rst with freeze → reset wins. s=1 with freeze=1 → no flag update.

Test Plan:
- rst=1 for one edge mid-stream with nonzero inputs → every registered output and status read 0 after the edge; holding rst for 2 edges keeps them at 0.
- ADD: val_rn=5, imm=1, shift_operand=12'h003, s=1, wb_en=1, dest=4 → next cycle alu_res_o=8, wb_en_o=1, dest_o=4, status=0000.
- SUB with s=1, val_rn=3, Val2=5 → alu_res_o=0xFFFFFFFE, status=1000 (N=1, C=0); then ADD 0x7FFFFFFF+1 → 0x80000000, status=1001.
- Val2 modes:
  - imm=1, shift_operand=12'h2FF → Val2=0xF000000F.
  - imm=0, val_rm=0x80000000, shift_operand={5'd4, 2'b10, 5'b0} → ASR gives 0xF8000000.
  - mem_w_en=1, shift_operand=12'hFFF, val_rn=0x100 → alu_res_o=0x10FF, st_val_o=val_rm.
- b=1, pc=0x100, imm_24=24'hFFFFFE → branch_taken=1, branch_addr=0xF8 in the same cycle.
- freeze=1 for 3 cycles while inputs change and s=1 → registered outputs and status are unchanged; the first edge after freeze deasserts captures the current inputs.
